// File: rtl/hpi_pkg.sv
// Shared definitions for the host port interface responder: register
// selects, STATUS bit layout and the STATUS word builder.
package hpi_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_MAILBOX = 2'd1,
    REG_ADDRESS = 2'd2,
    REG_STATUS  = 2'd3
  } hpi_reg_e;

  localparam int STAT_MBX_OUT = 0;
  localparam int STAT_MBX_IN  = 8;

  function automatic logic [15:0] status_word(input logic mbx_in, input logic mbx_out);
    logic [15:0] word;
    word               = 16'h0000;
    word[STAT_MBX_IN]  = mbx_in;
    word[STAT_MBX_OUT] = mbx_out;
    return word;
  endfunction

endpackage

// File: rtl/hpi_word_ram.sv
// 16-bit word memory: one write port, registered read with one-cycle latency.
// Contents are deliberately not reset.
module hpi_word_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem_r [0:(2**AW)-1];
  logic [15:0] rdata_r;

  // Memory write and synchronous read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/hpi_responder.sv
// Host port interface responder: strobe-edge access decode, auto-incrementing
// memory window, bidirectional mailbox and a device-side memory preload port.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              otg_hpi_cs,
  input  logic [1:0]        otg_hpi_address,
  input  logic              otg_hpi_r,
  input  logic              otg_hpi_w,
  input  logic [15:0]       hpi_wdata,
  output logic [15:0]       hpi_rdata,
  output logic              hpi_int,
  input  logic              dev_mbx_wr,
  input  logic [15:0]       dev_mbx_wdata,
  output logic              dev_mbx_valid,
  output logic [15:0]       dev_mbx_rdata,
  input  logic              dev_mbx_ack,
  input  logic              dev_mem_we,
  input  logic [MEM_AW-1:0] dev_mem_addr,
  input  logic [15:0]       dev_mem_wdata,
  output logic              dev_mem_ready
);

  logic              r_prev_r, w_prev_r;
  logic              rd_acc_s, wr_acc_s;
  hpi_reg_e          sel_s;
  logic              data_wr_s, data_rd_s, mbx_wr_s, mbx_rd_s;
  logic              addr_wr_s, addr_rd_s, stat_rd_s, host_data_s;

  logic [15:0]       addr_r, addr_nx_s;
  logic [15:0]       inbound_r, inbound_nx_s;
  logic [15:0]       outbound_r, outbound_nx_s;
  logic              mbx_in_r, mbx_in_nx_s;
  logic              mbx_out_r, mbx_out_nx_s;
  logic [15:0]       rdata_r, rdata_nx_s;
  logic              data_pend_r;
  logic              hpi_int_r;

  logic              ram_we_s;
  logic [MEM_AW-1:0] ram_waddr_s, word_idx_s;
  logic [15:0]       ram_wdata_s, ram_q_s;

  assign word_idx_s = addr_r[MEM_AW:1];

  // Falling-edge detect on each strobe; simultaneous falls and reset cycles make no access.
  always_comb begin
    rd_acc_s = !reset && !otg_hpi_cs && r_prev_r && !otg_hpi_r && !(w_prev_r && !otg_hpi_w);
    wr_acc_s = !reset && !otg_hpi_cs && w_prev_r && !otg_hpi_w && !(r_prev_r && !otg_hpi_r);
    sel_s    = hpi_reg_e'(otg_hpi_address);
  end

  // Register-select decode of the qualified access.
  always_comb begin
    data_wr_s = 1'b0;
    data_rd_s = 1'b0;
    mbx_wr_s  = 1'b0;
    mbx_rd_s  = 1'b0;
    addr_wr_s = 1'b0;
    addr_rd_s = 1'b0;
    stat_rd_s = 1'b0;
    case (sel_s)
      REG_DATA: begin
        data_wr_s = wr_acc_s;
        data_rd_s = rd_acc_s;
      end
      REG_MAILBOX: begin
        mbx_wr_s = wr_acc_s;
        mbx_rd_s = rd_acc_s;
      end
      REG_ADDRESS: begin
        addr_wr_s = wr_acc_s;
        addr_rd_s = rd_acc_s;
      end
      REG_STATUS: begin
        stat_rd_s = rd_acc_s;
      end
      default: begin
        data_wr_s = 1'b0;
      end
    endcase
    host_data_s = data_wr_s || data_rd_s;
  end

  // Next-state for address pointer, mailboxes and read-data holding register.
  always_comb begin
    addr_nx_s     = addr_r;
    inbound_nx_s  = inbound_r;
    outbound_nx_s = outbound_r;
    mbx_in_nx_s   = mbx_in_r;
    mbx_out_nx_s  = mbx_out_r;
    rdata_nx_s    = rdata_r;

    if (addr_wr_s) begin
      addr_nx_s = hpi_wdata;
    end else if (host_data_s) begin
      addr_nx_s = addr_r + 16'd2;
    end else begin
      addr_nx_s = addr_r;
    end

    // A host write in the same cycle as the device ack keeps the mailbox full.
    if (mbx_wr_s) begin
      inbound_nx_s = hpi_wdata;
      mbx_in_nx_s  = 1'b1;
    end else if (dev_mbx_ack && mbx_in_r) begin
      mbx_in_nx_s = 1'b0;
    end else begin
      mbx_in_nx_s = mbx_in_r;
    end

    // A device post in the same cycle as the host read leaves the new word pending.
    if (dev_mbx_wr) begin
      outbound_nx_s = dev_mbx_wdata;
      mbx_out_nx_s  = 1'b1;
    end else if (mbx_rd_s) begin
      mbx_out_nx_s = 1'b0;
    end else begin
      mbx_out_nx_s = mbx_out_r;
    end

    if (mbx_rd_s) begin
      rdata_nx_s = outbound_r;
    end else if (addr_rd_s) begin
      rdata_nx_s = addr_r;
    end else if (stat_rd_s) begin
      rdata_nx_s = status_word(mbx_in_r, mbx_out_r);
    end else if (data_pend_r) begin
      rdata_nx_s = ram_q_s;
    end else begin
      rdata_nx_s = rdata_r;
    end
  end

  // Memory write arbitration: any host DATA access locks out the device port.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = word_idx_s;
    ram_wdata_s = hpi_wdata;
    if (data_wr_s) begin
      ram_we_s = 1'b1;
    end else if (dev_mem_we && !host_data_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = dev_mem_addr;
      ram_wdata_s = dev_mem_wdata;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // State registers with synchronous reset; memory contents are untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_r    <= 1'b1;
      w_prev_r    <= 1'b1;
      addr_r      <= 16'h0000;
      inbound_r   <= 16'h0000;
      outbound_r  <= 16'h0000;
      mbx_in_r    <= 1'b0;
      mbx_out_r   <= 1'b0;
      rdata_r     <= 16'h0000;
      data_pend_r <= 1'b0;
      hpi_int_r   <= 1'b0;
    end else begin
      r_prev_r    <= otg_hpi_r;
      w_prev_r    <= otg_hpi_w;
      addr_r      <= addr_nx_s;
      inbound_r   <= inbound_nx_s;
      outbound_r  <= outbound_nx_s;
      mbx_in_r    <= mbx_in_nx_s;
      mbx_out_r   <= mbx_out_nx_s;
      rdata_r     <= rdata_nx_s;
      data_pend_r <= data_rd_s;
      hpi_int_r   <= mbx_out_nx_s;
    end
  end

  hpi_word_ram #(
    .AW(MEM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .waddr(ram_waddr_s),
    .wdata(ram_wdata_s),
    .raddr(word_idx_s),
    .rdata(ram_q_s)
  );

  // The RAM output register is shown directly in the cycle after a DATA read,
  // then captured into the holding register.
  assign hpi_rdata     = data_pend_r ? ram_q_s : rdata_r;
  assign hpi_int       = hpi_int_r;
  assign dev_mbx_valid = mbx_in_r;
  assign dev_mbx_rdata = inbound_r;
  assign dev_mem_ready = !host_data_s;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed self-checking bench for hpi_responder; inputs change on the falling
// clock edge and outputs are sampled there as well.
module tb_hpi_responder;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        otg_hpi_cs;
  logic [1:0]  otg_hpi_address;
  logic        otg_hpi_r;
  logic        otg_hpi_w;
  logic [15:0] hpi_wdata;
  logic [15:0] hpi_rdata;
  logic        hpi_int;
  logic        dev_mbx_wr;
  logic [15:0] dev_mbx_wdata;
  logic        dev_mbx_valid;
  logic [15:0] dev_mbx_rdata;
  logic        dev_mbx_ack;
  logic        dev_mem_we;
  logic [7:0]  dev_mem_addr;
  logic [15:0] dev_mem_wdata;
  logic        dev_mem_ready;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] rd;
  logic        rd_int;

  hpi_responder #(.MEM_AW(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .otg_hpi_cs     (otg_hpi_cs),
    .otg_hpi_address(otg_hpi_address),
    .otg_hpi_r      (otg_hpi_r),
    .otg_hpi_w      (otg_hpi_w),
    .hpi_wdata      (hpi_wdata),
    .hpi_rdata      (hpi_rdata),
    .hpi_int        (hpi_int),
    .dev_mbx_wr     (dev_mbx_wr),
    .dev_mbx_wdata  (dev_mbx_wdata),
    .dev_mbx_valid  (dev_mbx_valid),
    .dev_mbx_rdata  (dev_mbx_rdata),
    .dev_mbx_ack    (dev_mbx_ack),
    .dev_mem_we     (dev_mem_we),
    .dev_mem_addr   (dev_mem_addr),
    .dev_mem_wdata  (dev_mem_wdata),
    .dev_mem_ready  (dev_mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    otg_hpi_cs = 1'b0; otg_hpi_address = a; hpi_wdata = d; otg_hpi_w = 1'b0;
    @(negedge clk);
    otg_hpi_w = 1'b1; otg_hpi_cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic host_read(input logic [1:0] a);
    otg_hpi_cs = 1'b0; otg_hpi_address = a; otg_hpi_r = 1'b0;
    @(negedge clk);
    rd = hpi_rdata; rd_int = hpi_int;
    otg_hpi_r = 1'b1; otg_hpi_cs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; otg_hpi_cs = 1'b1; otg_hpi_address = 2'd0; otg_hpi_r = 1'b1; otg_hpi_w = 1'b1;
    hpi_wdata = 16'h0000; dev_mbx_wr = 1'b0; dev_mbx_wdata = 16'h0000; dev_mbx_ack = 1'b0;
    dev_mem_we = 1'b0; dev_mem_addr = 8'h00; dev_mem_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_rdata", hpi_rdata, 16'h0000);
    chk("rst_int", 16'(hpi_int), 16'h0000);
    chk("rst_valid", 16'(dev_mbx_valid), 16'h0000);
    chk("rst_mbx_rdata", dev_mbx_rdata, 16'h0000);
    chk("rst_ready", 16'(dev_mem_ready), 16'h0001);
    reset = 1'b0;
    @(negedge clk);
    host_read(A_ADDR); chk("rst_addr", rd, 16'h0000);
    host_read(A_STAT); chk("rst_status", rd, 16'h0000);

    // Auto-increment window
    host_write(A_ADDR, 16'h0010);
    host_write(A_DATA, 16'hBEEF);
    host_write(A_DATA, 16'h1234);
    host_write(A_ADDR, 16'h0010);
    host_read(A_DATA); chk("rd_data0", rd, 16'hBEEF);
    chk("rd_hold", hpi_rdata, 16'hBEEF);
    host_read(A_DATA); chk("rd_data1", rd, 16'h1234);
    host_read(A_ADDR); chk("rd_addr_inc", rd, 16'h0014);
    host_write(A_ADDR, 16'h0020);
    chk("wr_keeps_rdata", hpi_rdata, 16'h0014);
    host_write(A_STAT, 16'hFFFF);
    host_read(A_STAT); chk("stat_wr_ignored", rd, 16'h0000);

    // Address wrap at top of 16-bit space
    host_write(A_ADDR, 16'hFFFE);
    host_write(A_DATA, 16'hAAAA);
    host_read(A_ADDR); chk("addr_wrap", rd, 16'h0000);
    host_write(A_ADDR, 16'hFFFE);
    host_read(A_DATA); chk("wrap_data", rd, 16'hAAAA);
    host_read(A_ADDR); chk("addr_wrap_rd", rd, 16'h0000);

    // Outbound mailbox
    dev_mbx_wr = 1'b1; dev_mbx_wdata = 16'h5A5A;
    @(negedge clk);
    dev_mbx_wr = 1'b0;
    @(negedge clk);
    chk("int_set", 16'(hpi_int), 16'h0001);
    host_read(A_STAT); chk("stat_out", rd, 16'h0001);
    host_read(A_MBX); chk("mbx_out_data", rd, 16'h5A5A);
    chk("int_clr", 16'(rd_int), 16'h0000);
    host_read(A_STAT); chk("stat_out_clr", rd, 16'h0000);

    // Device post coincident with host mailbox read
    dev_mbx_wr = 1'b1; dev_mbx_wdata = 16'h1111;
    @(negedge clk);
    dev_mbx_wr = 1'b0;
    @(negedge clk);
    otg_hpi_cs = 1'b0; otg_hpi_address = A_MBX; otg_hpi_r = 1'b0;
    dev_mbx_wr = 1'b1; dev_mbx_wdata = 16'h2222;
    @(negedge clk);
    chk("race_old", hpi_rdata, 16'h1111);
    chk("race_int", 16'(hpi_int), 16'h0001);
    otg_hpi_r = 1'b1; otg_hpi_cs = 1'b1; dev_mbx_wr = 1'b0;
    @(negedge clk);
    host_read(A_MBX); chk("race_new", rd, 16'h2222);
    chk("race_int_clr", 16'(rd_int), 16'h0000);

    // Inbound mailbox
    host_write(A_MBX, 16'h00C3);
    chk("in_valid", 16'(dev_mbx_valid), 16'h0001);
    chk("in_rdata", dev_mbx_rdata, 16'h00C3);
    host_read(A_STAT); chk("stat_in", rd, 16'h0100);
    otg_hpi_cs = 1'b0; otg_hpi_address = A_MBX; hpi_wdata = 16'h00C4; otg_hpi_w = 1'b0;
    dev_mbx_ack = 1'b1;
    @(negedge clk);
    dev_mbx_ack = 1'b0; otg_hpi_w = 1'b1; otg_hpi_cs = 1'b1;
    @(negedge clk);
    chk("ack_race_valid", 16'(dev_mbx_valid), 16'h0001);
    chk("ack_race_rdata", dev_mbx_rdata, 16'h00C4);
    dev_mbx_ack = 1'b1;
    @(negedge clk);
    dev_mbx_ack = 1'b0;
    chk("ack_valid", 16'(dev_mbx_valid), 16'h0000);

    // Non-accesses: simultaneous strobes, and chip select high
    host_write(A_ADDR, 16'h0030);
    host_write(A_DATA, 16'h7777);
    host_write(A_DATA, 16'h8888);
    host_write(A_ADDR, 16'h0030);
    host_read(A_ADDR); chk("na_setup", rd, 16'h0030);
    otg_hpi_cs = 1'b0; otg_hpi_address = A_DATA; hpi_wdata = 16'h9999;
    otg_hpi_r = 1'b0; otg_hpi_w = 1'b0;
    @(negedge clk);
    otg_hpi_r = 1'b1; otg_hpi_w = 1'b1; otg_hpi_cs = 1'b1;
    @(negedge clk);
    chk("both_rdata", hpi_rdata, 16'h0030);
    otg_hpi_address = A_DATA; otg_hpi_w = 1'b0;
    @(negedge clk);
    otg_hpi_w = 1'b1;
    @(negedge clk);
    otg_hpi_address = A_STAT; otg_hpi_r = 1'b0;
    @(negedge clk);
    otg_hpi_r = 1'b1;
    @(negedge clk);
    chk("cs_rdata", hpi_rdata, 16'h0030);
    host_read(A_ADDR); chk("na_addr", rd, 16'h0030);
    host_read(A_DATA); chk("na_mem0", rd, 16'h7777);
    host_read(A_DATA); chk("na_mem1", rd, 16'h8888);

    // Device preload port and host priority
    dev_mem_we = 1'b1; dev_mem_addr = 8'd6; dev_mem_wdata = 16'h6666;
    #1 chk("dev_ready", 16'(dev_mem_ready), 16'h0001);
    @(negedge clk);
    dev_mem_we = 1'b0;
    host_write(A_ADDR, 16'h000A);
    otg_hpi_cs = 1'b0; otg_hpi_address = A_DATA; hpi_wdata = 16'h1357; otg_hpi_w = 1'b0;
    dev_mem_we = 1'b1; dev_mem_addr = 8'd5; dev_mem_wdata = 16'hDEAD;
    #1 chk("dev_blocked", 16'(dev_mem_ready), 16'h0000);
    @(negedge clk);
    otg_hpi_w = 1'b1; otg_hpi_cs = 1'b1; dev_mem_we = 1'b0;
    @(negedge clk);
    host_write(A_ADDR, 16'h000A);
    host_read(A_DATA); chk("host_wins", rd, 16'h1357);
    host_read(A_DATA); chk("dev_preload", rd, 16'h6666);

    // Reset in the middle of a DATA write
    host_write(A_ADDR, 16'h0040);
    host_write(A_DATA, 16'h4444);
    host_write(A_ADDR, 16'h0040);
    reset = 1'b1; otg_hpi_cs = 1'b0; otg_hpi_address = A_DATA; hpi_wdata = 16'hBAD0; otg_hpi_w = 1'b0;
    @(negedge clk);
    chk("rst2_rdata", hpi_rdata, 16'h0000);
    reset = 1'b0; otg_hpi_w = 1'b1; otg_hpi_cs = 1'b1;
    @(negedge clk);
    host_read(A_ADDR); chk("rst2_addr", rd, 16'h0000);
    host_write(A_ADDR, 16'h0040);
    host_read(A_DATA); chk("rst2_mem", rd, 16'h4444);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
